twiddle_factor_sequencer: RTL and testbench

- Sequential successor to the combinational per-stage twiddle broadcaster.
- Generates per-stage NTT twiddle vectors internally by repeated modular multiplication from a single runtime root, instead of taking a precomputed D-entry table.
- Supports forward and inverse transforms and streams one D-lane vector per butterfly stage to the NTT datapath over a valid/ready handshake.
- Sits between the NTT control FSM and the butterfly array.

---
 rtl/ntt_pkg.sv | 24 ++
 rtl/twiddle_factor_sequencer_if.sv | 19 +
 rtl/twiddle_factor_sequencer_mod_mul.sv | 22 ++
 rtl/twiddle_factor_sequencer.sv | 156 +++++++++++++++
 tb/tb_twiddle_factor_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT defaults, stage-count helpers and the twiddle sequencer FSM encoding.
package ntt_pkg;

  localparam int NTT_N = 17;
  localparam int NTT_D = 16;
  localparam int NTT_Q = 65537;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    GEN  = 2'd2,
    OUT  = 2'd3
  } tfs_state_t;

  function automatic int stage_count(input int d);
    return $clog2(d);
  endfunction

  // Width of the stage index; never narrower than one bit.
  function automatic int stage_idx_w(input int d);
    return ($clog2(d) > 1) ? $clog2($clog2(d)) : 1;
  endfunction

endpackage

// File: rtl/twiddle_factor_sequencer_if.sv
// Twiddle vector stream from the sequencer to the butterfly array (valid/ready).
interface twiddle_factor_sequencer_if
  import ntt_pkg::*;
#(
  parameter int N = NTT_N,
  parameter int D = NTT_D
);

  localparam int SW = stage_idx_w(D);

  logic [D*N-1:0] tf;
  logic [SW-1:0]  tf_stage;
  logic           tf_valid;
  logic           tf_ready;

  modport master (output tf, tf_stage, tf_valid, input tf_ready);
  modport slave  (input tf, tf_stage, tf_valid, output tf_ready);

endinterface

// File: rtl/twiddle_factor_sequencer_mod_mul.sv
// Modular multiplier: p = a*b mod Q.
// Latency: combinational. Backpressure: none.
// Full 2N-bit product reduced in the same cycle; result always < Q.
module mod_mul
  import ntt_pkg::*;
#(
  parameter int N = NTT_N,
  parameter int Q = NTT_Q
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] p
);

  localparam logic [2*N-1:0] QW = (2*N)'(Q);

  logic [2*N-1:0] prod;

  assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
  assign p    = N'(prod % QW);

endmodule

// File: rtl/twiddle_factor_sequencer.sv
// Twiddle sequencer: builds one D-lane NTT twiddle vector per stage from a single runtime root.
// Latency: stage i valid S-1+sum_{k<=i}(2^k+1) cycles after start; done one cycle after last handshake.
// Backpressure: tf/tf_stage held with tf_valid high until tf_ready; generation waits in OUT.
module twiddle_factor_sequencer
  import ntt_pkg::*;
#(
  parameter int N = NTT_N,
  parameter int D = NTT_D,
  parameter int Q = NTT_Q
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              inv,
  input  logic [N-1:0]                      root,
  input  logic [N-1:0]                      root_inv,
  twiddle_factor_sequencer_if.master        tf_if,
  output logic                              busy,
  output logic                              done
);

  localparam int S     = stage_count(D);
  localparam int SW    = stage_idx_w(D);
  localparam int GW    = S;
  localparam int PIDX0 = (S > 1) ? S - 2 : 0;
  localparam logic [N-1:0] QN = N'(Q);

  tfs_state_t          state_q, state_d;
  logic [N-1:0]        step [S];
  logic [D-1:0][N-1:0] tf_q;
  logic [SW-1:0]       stage_q;
  logic [SW-1:0]       pidx_q;
  logic [GW-1:0]       grp_q;
  logic [N-1:0]        prev_q;
  logic                done_q;

  logic [N-1:0]        base_red;
  logic [N-1:0]        sq_src;
  logic [N-1:0]        stage_step;
  logic [N-1:0]        mul_a;
  logic [N-1:0]        mul_b;
  logic [N-1:0]        mul_p;
  logic [N-1:0]        gen_val;
  logic                last_grp;
  logic                last_stage;
  logic                valid;
  logic                hs;

  // Roots at or above Q are folded back into range when latched.
  assign base_red   = (inv ? root_inv : root) % QN;

  assign last_grp   = (int'(grp_q) == (1 << int'(stage_q)) - 1);
  assign last_stage = (int'(stage_q) == S - 1);
  assign hs         = valid & tf_if.tf_ready;
  assign gen_val    = (grp_q == '0) ? N'(1) : mul_p;

  // One multiplier shared: squaring in PREP, prev*step[stage] in GEN.
  always_comb begin
    sq_src     = '0;
    stage_step = '0;
    for (int k = 0; k < S; k++) begin
      if (k == int'(pidx_q) + 1) sq_src = step[k];
      if (k == int'(stage_q))    stage_step = step[k];
    end
    mul_a = (state_q == PREP) ? sq_src : prev_q;
    mul_b = (state_q == PREP) ? sq_src : stage_step;
  end

  mod_mul #(
    .N(N),
    .Q(Q)
  ) u_mod_mul (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = (S == 1) ? GEN : PREP;
      end
      PREP: begin
        if (pidx_q == '0) state_d = GEN;
      end
      GEN: begin
        if (last_grp) state_d = OUT;
      end
      OUT: begin
        valid = 1'b1;
        if (tf_if.tf_ready) state_d = last_stage ? IDLE : GEN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < S; k++) step[k] <= '0;
      tf_q    <= '0;
      stage_q <= '0;
      pidx_q  <= '0;
      grp_q   <= '0;
      prev_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            step[S-1] <= base_red;
            stage_q   <= '0;
            pidx_q    <= SW'(PIDX0);
            grp_q     <= '0;
          end
        end
        PREP: begin
          for (int k = 0; k < S; k++) begin
            if (k == int'(pidx_q)) step[k] <= mul_p;
          end
          pidx_q <= pidx_q - SW'(1);
        end
        GEN: begin
          // Lane l belongs to group l >> (S - stage) at this stage.
          for (int l = 0; l < D; l++) begin
            if ((l >> (S - int'(stage_q))) == int'(grp_q)) tf_q[l] <= gen_val;
          end
          prev_q <= gen_val;
          grp_q  <= last_grp ? '0 : grp_q + GW'(1);
        end
        OUT: begin
          if (hs) begin
            if (last_stage) done_q  <= 1'b1;
            else            stage_q <= stage_q + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign tf_if.tf       = tf_q;
  assign tf_if.tf_stage = stage_q;
  assign tf_if.tf_valid = valid;
  assign done           = done_q;

endmodule

// File: tb/tb_twiddle_factor_sequencer.sv
// Bench for twiddle_factor_sequencer: a D=4 instance for directed timing vectors and a D=16 instance
// checked against a power-based reference model under random roots and random tf_ready stalls.
module tb_twiddle_factor_sequencer;

  localparam int N = 17;
  localparam int Q = 65537;
  localparam int W = 16 * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start4, inv4, busy4, done4;
  logic [N-1:0] root4, rinv4;
  logic         start16, inv16, busy16, done16;
  logic [N-1:0] root16, rinv16;

  twiddle_factor_sequencer_if #(.N(N), .D(4))  if4 ();
  twiddle_factor_sequencer_if #(.N(N), .D(16)) if16 ();

  twiddle_factor_sequencer #(.N(N), .D(4), .Q(Q)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .inv(inv4), .root(root4), .root_inv(rinv4),
    .tf_if(if4.master), .busy(busy4), .done(done4)
  );

  twiddle_factor_sequencer #(.N(N), .D(16), .Q(Q)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .inv(inv16), .root(root16), .root_inv(rinv16),
    .tf_if(if16.master), .busy(busy16), .done(done16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic longint powmod(input longint b, input longint e);
    longint r, x, k;
    r = 1;
    x = b % Q;
    k = e;
    while (k > 0) begin
      if (k[0]) r = (r * x) % Q;
      x = (x * x) % Q;
      k = k >> 1;
    end
    return r;
  endfunction

  // Stage i uses base^(2^(S-1-i)); lane l sits in group l / (D / 2^i) and carries that value to the group index.
  function automatic logic [W-1:0] model_tf(input int d, input longint base, input int stage);
    int s;
    longint j;
    logic [W-1:0] v;
    s = $clog2(d);
    v = '0;
    for (int l = 0; l < d; l++) begin
      j = l / (d / (1 << stage));
      v[l*N +: N] = N'(powmod(base, j * (longint'(1) << (s - 1 - stage))));
    end
    return v;
  endfunction

  function automatic int hs_cycle(input int s, input int i);
    int c;
    c = s - 1;
    for (int k = 0; k <= i; k++) c += (1 << k) + 1;
    return c;
  endfunction

  function automatic logic [4*N-1:0] lanes4(input int a, input int b, input int c, input int d);
    return {N'(d), N'(c), N'(b), N'(a)};
  endfunction

  typedef struct {
    logic         inv;
    logic [N-1:0] root;
    logic [N-1:0] rinv;
    int           stall;
    int           dup;
    int           c0;
    int           c1;
    int           cd;
    logic [4*N-1:0] tf0;
    logic [4*N-1:0] tf1;
  } vec4_t;

  task automatic run4(input vec4_t v, input int id);
    int cyc, c0, c1, cd;
    logic [4*N-1:0] t0, t1;
    logic hold_ok, busy1, busy_at_done;
    cyc = 0; c0 = -1; c1 = -1; cd = -1;
    t0 = '0; t1 = '0; hold_ok = 1'b1; busy1 = 1'b0; busy_at_done = 1'b1;
    @(negedge clk);
    inv4 = v.inv; root4 = v.root; rinv4 = v.rinv; start4 = 1'b1;
    if4.tf_ready = 1'b1;
    while (cd < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start4 = (v.dup != 0) && (cyc == v.dup || cyc == v.dup + 2);
      if4.tf_ready = !(cyc >= v.c0 && cyc < v.c0 + v.stall);
      if (cyc == 1) busy1 = busy4;
      if (c0 >= 0 && cyc > c0 && cyc <= c0 + v.stall &&
          !(if4.tf_valid && if4.tf == t0 && if4.tf_stage == 1'b0)) hold_ok = 1'b0;
      if (if4.tf_valid && if4.tf_stage == 1'b0 && c0 < 0) begin c0 = cyc; t0 = if4.tf; end
      if (if4.tf_valid && if4.tf_stage == 1'b1 && c1 < 0) begin c1 = cyc; t1 = if4.tf; end
      if (done4) begin cd = cyc; busy_at_done = busy4; end
    end
    chk($sformatf("v%0d_busy_c1", id), busy1, 1);
    chk($sformatf("v%0d_c0", id), c0, v.c0);
    chk($sformatf("v%0d_tf0", id), t0, v.tf0);
    chk($sformatf("v%0d_c1", id), c1, v.c1);
    chk($sformatf("v%0d_tf1", id), t1, v.tf1);
    chk($sformatf("v%0d_done_cyc", id), cd, v.cd);
    chk($sformatf("v%0d_busy_done", id), busy_at_done, 0);
    if (v.stall > 0) chk($sformatf("v%0d_stall_hold", id), hold_ok, 1);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", id), done4, 0);
  endtask

  task automatic run16(input int id, input logic inv, input logic [N-1:0] root,
                       input logic [N-1:0] rinv, input bit stalls, output logic [W-1:0] last_tf);
    longint base;
    int cyc, st, last_hs, dn;
    logic pv, phs, hold_ok;
    logic [W-1:0] ptf;
    logic [1:0] pst;
    base = inv ? rinv : root;
    cyc = 0; st = 0; last_hs = -1; dn = -1;
    pv = 1'b0; phs = 1'b0; hold_ok = 1'b1; ptf = '0; pst = '0; last_tf = '0;
    @(negedge clk);
    inv16 = inv; root16 = root; rinv16 = rinv; start16 = 1'b1; if16.tf_ready = 1'b1;
    while (dn < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start16 = 1'b0;
      if16.tf_ready = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pv && !phs && !(if16.tf_valid && if16.tf == ptf && if16.tf_stage == pst)) hold_ok = 1'b0;
      phs = if16.tf_valid && if16.tf_ready;
      pv  = if16.tf_valid;
      ptf = if16.tf;
      pst = if16.tf_stage;
      if (phs) begin
        chk($sformatf("r%0d_stage", id), if16.tf_stage, st);
        if (st < 4) chk($sformatf("r%0d_tf_s%0d", id, st), if16.tf, model_tf(16, base, st));
        if (!stalls && st < 4) chk($sformatf("r%0d_hs_cyc_s%0d", id, st), cyc, hs_cycle(4, st));
        if (st == 3) last_tf = if16.tf;
        last_hs = cyc;
        st++;
      end
      if (done16) dn = cyc;
    end
    chk($sformatf("r%0d_stage_count", id), st, 4);
    chk($sformatf("r%0d_done_cyc", id), dn, last_hs + 1);
    chk($sformatf("r%0d_hold", id), hold_ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vec4_t tbl[6];
    logic [W-1:0] lt;
    tbl[0] = '{inv: 1'b0, root: 17'd256, rinv: 17'd65281, stall: 0, dup: 0, c0: 3, c1: 6, cd: 7,
               tf0: lanes4(1, 1, 1, 1), tf1: lanes4(1, 1, 256, 256)};
    tbl[1] = '{inv: 1'b1, root: 17'd256, rinv: 17'd65281, stall: 0, dup: 0, c0: 3, c1: 6, cd: 7,
               tf0: lanes4(1, 1, 1, 1), tf1: lanes4(1, 1, 65281, 65281)};
    tbl[2] = '{inv: 1'b0, root: 17'd256, rinv: 17'd65281, stall: 5, dup: 0, c0: 3, c1: 11, cd: 12,
               tf0: lanes4(1, 1, 1, 1), tf1: lanes4(1, 1, 256, 256)};
    tbl[3] = '{inv: 1'b0, root: 17'd256, rinv: 17'd65281, stall: 0, dup: 2, c0: 3, c1: 6, cd: 7,
               tf0: lanes4(1, 1, 1, 1), tf1: lanes4(1, 1, 256, 256)};
    tbl[4] = '{inv: 1'b0, root: 17'd65793, rinv: 17'd130818, stall: 0, dup: 0, c0: 3, c1: 6, cd: 7,
               tf0: lanes4(1, 1, 1, 1), tf1: lanes4(1, 1, 256, 256)};
    tbl[5] = '{inv: 1'b1, root: 17'd65793, rinv: 17'd130818, stall: 0, dup: 0, c0: 3, c1: 6, cd: 7,
               tf0: lanes4(1, 1, 1, 1), tf1: lanes4(1, 1, 65281, 65281)};

    rst = 1'b1;
    start4 = 1'b0; inv4 = 1'b0; root4 = '0; rinv4 = '0; if4.tf_ready = 1'b0;
    start16 = 1'b0; inv16 = 1'b0; root16 = '0; rinv16 = '0; if16.tf_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst4_tf", if4.tf, 0);
    chk("rst4_stage", if4.tf_stage, 0);
    chk("rst4_valid", if4.tf_valid, 0);
    chk("rst4_busy", busy4, 0);
    chk("rst4_done", done4, 0);
    chk("rst16_tf", if16.tf, 0);
    chk("rst16_valid", if16.tf_valid, 0);
    chk("rst16_busy", busy16, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run4(tbl[i], i);

    // Reset during stage-1 generation, then a clean sequence afterwards.
    @(negedge clk);
    inv4 = 1'b0; root4 = 17'd256; rinv4 = 17'd65281; start4 = 1'b1; if4.tf_ready = 1'b1;
    repeat (4) begin @(negedge clk); start4 = 1'b0; end
    chk("mid_busy", busy4, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tf", if4.tf, 0);
    chk("mid_rst_stage", if4.tf_stage, 0);
    chk("mid_rst_valid", if4.tf_valid, 0);
    chk("mid_rst_busy", busy4, 0);
    chk("mid_rst_done", done4, 0);
    rst = 1'b0;
    run4(tbl[0], 10);

    // Start in the done cycle is taken because the FSM is already idle.
    @(negedge clk);
    inv4 = 1'b0; root4 = 17'd256; rinv4 = 17'd65281; start4 = 1'b1; if4.tf_ready = 1'b1;
    repeat (7) begin @(negedge clk); start4 = 1'b0; end
    chk("b2b_done", done4, 1);
    inv4 = 1'b1; start4 = 1'b1;
    repeat (3) begin @(negedge clk); start4 = 1'b0; end
    chk("b2b_s0", {if4.tf_valid, if4.tf_stage}, 2'b10);
    repeat (3) @(negedge clk);
    chk("b2b_s1", {if4.tf_valid, if4.tf_stage}, 2'b11);
    chk("b2b_tf1", if4.tf, lanes4(1, 1, 65281, 65281));
    @(negedge clk);
    chk("b2b_done2", done4, 1);

    // 4096 has order 8 mod 65537 (2^32 = 1), so 4096^3 = 2^36 = 16.
    run16(0, 1'b0, 17'd4096, 17'd0, 1'b0, lt);
    chk("d16_lane2", lt[2*N +: N], 4096);
    chk("d16_lane4", lt[4*N +: N], 65281);
    chk("d16_lane6", lt[6*N +: N], 16);

    for (int r = 1; r <= 12; r++) begin
      run16(r, 1'($urandom_range(0, 1)), N'($urandom_range(0, (1 << N) - 1)),
            N'($urandom_range(0, (1 << N) - 1)), 1'b1, lt);
    end
    run16(13, 1'b1, N'($urandom_range(1, Q - 1)), N'($urandom_range(1, Q - 1)), 1'b0, lt);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
